// File: rtl/kp_pkg.sv
// Shared types for the 4x4 keypad scanner: FSM states, scan-result encoding, key map.
package kp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    HELD,
    RELEASE
  } kp_state_e;

  // Scan result: bit 4 set means no key (none pressed, or more than one pressed).
  typedef logic [4:0] scan_res_t;
  localparam scan_res_t RES_NONE = 5'h10;

  // Indexed by {col, row}.
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hC, 4'hB, 4'hA,
    4'hE, 4'h9, 4'h6, 4'h3,
    4'hF, 4'h8, 4'h5, 4'h2,
    4'h0, 4'h7, 4'h4, 4'h1
  };

  function automatic logic [3:0] kp_key(input logic [1:0] col, input logic [1:0] row);
    return KEY_MAP[{col, row}];
  endfunction

endpackage

// File: rtl/kp_sync.sv
// Two-flop synchronizer for the asynchronous keypad row inputs; idles high.
module kp_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta_q, sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 4'hF;
      sync_q <= 4'hF;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with per-scan debounce FSM.
// Define KEYPAD_REPEAT_EN to re-pulse key_valid every REPEAT_SCANS scans while held.
module keypad_scanner
  import kp_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] col_n,
  input  logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int              SLOT_W    = $clog2(SCAN_DIV);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [3:0]      DBC_N     = 4'(DEBOUNCE_SCANS);

  logic [3:0] row_s;

  kp_sync u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (row_n),
    .q    (row_s)
  );

  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [1:0]        col_idx_q, col_idx_d;
  logic [3:0]        col_n_q, col_n_d;
  logic [1:0]        acc_hits_q, acc_hits_d;
  logic [3:0]        acc_key_q, acc_key_d;
  kp_state_e         state_q, state_d;
  logic [3:0]        cand_q, cand_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        key_code_q, key_code_d;
  logic              key_valid_q, key_valid_d;
  logic              key_held_q, key_held_d;

`ifdef KEYPAD_REPEAT_EN
  localparam int               REP_W = $clog2(REPEAT_SCANS + 1);
  localparam logic [REP_W-1:0] REP_N = REP_W'(REPEAT_SCANS);
  logic [REP_W-1:0] rep_q, rep_d;
`else
  logic unused_repeat;
  assign unused_repeat = (REPEAT_SCANS != 0);
`endif

  logic      slot_end, scan_done;
  logic [3:0] row_low;
  logic [2:0] n_low, hits_sum;
  logic [1:0] row_idx;
  logic [3:0] cur_key;
  scan_res_t  scan_res;

  // Hits are accumulated across the four columns (saturating at 2) so a
  // multi-key press anywhere in the scan collapses to NONE.
  always_comb begin : scan_c
    slot_end  = (slot_q == SLOT_LAST);
    scan_done = slot_end && (col_idx_q == 2'd3);
    row_low   = ~row_s;
    n_low     = '0;
    row_idx   = '0;
    for (int r = 3; r >= 0; r--) begin
      if (row_low[r]) begin
        n_low   = n_low + 3'd1;
        row_idx = 2'(r);
      end
    end
    cur_key  = kp_key(col_idx_q, row_idx);
    hits_sum = {1'b0, acc_hits_q} + n_low;

    slot_d     = slot_end ? '0 : slot_q + 1'b1;
    col_idx_d  = col_idx_q;
    col_n_d    = col_n_q;
    acc_hits_d = acc_hits_q;
    acc_key_d  = acc_key_q;
    scan_res   = RES_NONE;
    if (slot_end) begin
      col_idx_d = col_idx_q + 2'd1;
      col_n_d   = {col_n_q[2:0], col_n_q[3]};
      if (acc_hits_q == 2'd0 && n_low == 3'd1) acc_key_d = cur_key;
      acc_hits_d = (hits_sum > 3'd2) ? 2'd2 : hits_sum[1:0];
      if (scan_done) begin
        if (hits_sum == 3'd1) scan_res = {1'b0, (acc_hits_q == 2'd1) ? acc_key_q : cur_key};
        acc_hits_d = '0;
      end
    end
  end

  always_comb begin : fsm_c
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
`ifdef KEYPAD_REPEAT_EN
    rep_d       = rep_q;
`endif
    if (scan_done) begin
      case (state_q)
        IDLE: begin
          if (scan_res != RES_NONE) begin
            state_d = DEBOUNCE;
            cand_d  = scan_res[3:0];
            cnt_d   = 4'd1;
          end
        end
        DEBOUNCE: begin
          if (scan_res == RES_NONE) begin
            state_d = IDLE;
          end else if (scan_res[3:0] != cand_q) begin
            cand_d = scan_res[3:0];
            cnt_d  = 4'd1;
          end else if (cnt_q + 4'd1 == DBC_N) begin
            state_d     = HELD;
            key_code_d  = cand_q;
            key_valid_d = 1'b1;
            key_held_d  = 1'b1;
`ifdef KEYPAD_REPEAT_EN
            rep_d       = '0;
`endif
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        HELD: begin
          if (scan_res == RES_NONE) begin
            state_d = RELEASE;
            cnt_d   = 4'd1;
          end else begin
`ifdef KEYPAD_REPEAT_EN
            if (rep_q + 1'b1 == REP_N) begin
              key_valid_d = 1'b1;
              rep_d       = '0;
            end else begin
              rep_d = rep_q + 1'b1;
            end
`endif
          end
        end
        RELEASE: begin
          if (scan_res != RES_NONE) begin
            state_d = HELD;
`ifdef KEYPAD_REPEAT_EN
            rep_d   = '0;
`endif
          end else if (cnt_q + 4'd1 == DBC_N) begin
            state_d    = IDLE;
            key_held_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q      <= '0;
      col_idx_q   <= '0;
      col_n_q     <= 4'b1110;
      acc_hits_q  <= '0;
      acc_key_q   <= '0;
      state_q     <= IDLE;
      cand_q      <= '0;
      cnt_q       <= '0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q       <= '0;
`endif
    end else begin
      slot_q      <= slot_d;
      col_idx_q   <= col_idx_d;
      col_n_q     <= col_n_d;
      acc_hits_q  <= acc_hits_d;
      acc_key_q   <= acc_key_d;
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q       <= rep_d;
`endif
    end
  end

  assign col_n     = col_n_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized bench for keypad_scanner against a run-length reference model of the key matrix.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DBS      = 3;
  localparam int REP      = 5;
  localparam int SCAN_CYC = 4 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  col_n, row_n, key_code;
  logic        key_valid, key_held;
  logic [15:0] press = '0;  // bit col*4+row

  int n_chk = 0, n_fail = 0, pulse_cnt = 0;
  int m_cand = 0, m_run = 0, m_none = 0, m_rep = 0, m_code = 0, m_pulses = 0;
  bit m_held = 1'b0;

  keypad_scanner #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DBS),
    .REPEAT_SCANS  (REP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .col_n    (col_n),
    .row_n    (row_n),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  // Passive switch matrix: a pressed key shorts its row to its column.
  always_comb begin
    row_n = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (press[c*4+r] && col_n[c] === 1'b0) row_n[r] = 1'b0;
  end

  always @(negedge clk) if (key_valid === 1'b1) pulse_cnt++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic int key_of(input int idx);
    logic [15:0] colv;
    case (idx / 4)
      0:       colv = 16'h1470;
      1:       colv = 16'h258F;
      2:       colv = 16'h369E;
      default: colv = 16'hABCD;
    endcase
    return int'((colv >> (4 * (3 - idx % 4))) & 16'hF);
  endfunction

  // Acceptance = DBS identical single-key scans in a row while released;
  // release = DBS empty scans in a row while held.
  task automatic model_scan(input logic [15:0] p, output bit pulse);
    int res;
    pulse = 1'b0;
    res = -1;
    if ($countones(p) == 1)
      for (int i = 0; i < 16; i++) if (p[i]) res = key_of(i);
    if (!m_held) begin
      if (res < 0) m_run = 0;
      else if (m_run > 0 && res == m_cand) m_run++;
      else begin m_cand = res; m_run = 1; end
      if (m_run == DBS) begin
        m_held = 1'b1; m_code = m_cand; pulse = 1'b1; m_none = 0; m_rep = 0;
      end
    end else if (res < 0) begin
      m_none++;
      if (m_none == DBS) begin m_held = 1'b0; m_run = 0; end
    end else if (m_none > 0) begin
      m_none = 0; m_rep = 0;
    end else begin
`ifdef KEYPAD_REPEAT_EN
      m_rep++;
      if (m_rep == REP) begin pulse = 1'b1; m_rep = 0; end
`endif
    end
    if (pulse) m_pulses++;
  endtask

  task automatic run_scan(input logic [15:0] p);
    bit pulse;
    logic [3:0] exp_col;
    press = p;
    model_scan(p, pulse);
    for (int i = 1; i <= SCAN_CYC; i++) begin
      @(posedge clk); #1;
      exp_col = ~(4'b0001 << ((i / SCAN_DIV) % 4));
      chk("col_n", col_n, exp_col);
    end
    chk("key_valid", key_valid, pulse);
    chk("key_code", key_code, m_code);
    chk("key_held", key_held, m_held);
  endtask

  task automatic do_reset();
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_async_col", col_n, 4'b1110);
    chk("rst_async_code", key_code, 4'h0);
    chk("rst_async_held", key_held, 1'b0);
    repeat (5) @(negedge clk);
    chk("rst_col", col_n, 4'b1110);
    chk("rst_code", key_code, 4'h0);
    chk("rst_valid", key_valid, 1'b0);
    chk("rst_held", key_held, 1'b0);
    m_held = 1'b0; m_run = 0; m_none = 0; m_rep = 0; m_code = 0;
    rst_n = 1'b1;
  endtask

  initial begin
    int p0;
    logic [15:0] p;
    do_reset();
    repeat (2) run_scan('0);

    // clean press of key 5 (col1,row1)
    repeat (3) run_scan(16'h0020);
    chk("press5_code", key_code, 4'h5);
    repeat (3) run_scan('0);
    chk("press5_pulses", pulse_cnt, m_pulses);

    // bouncing key 9 (col2,row2), then stable
    p0 = pulse_cnt;
    for (int i = 0; i < 4; i++) run_scan((i % 2 == 0) ? 16'h0400 : 16'h0000);
    chk("bounce_quiet", pulse_cnt - p0, 0);
    repeat (3) run_scan(16'h0400);
    chk("bounce_code", key_code, 4'h9);
    repeat (3) run_scan('0);
    chk("bounce_pulses", pulse_cnt - p0, 1);

    // two rows low in col3 -> no key
    p0 = pulse_cnt;
    repeat (4) run_scan(16'h5000);
    chk("ghost_pulses", pulse_cnt - p0, 0);
    chk("ghost_code", key_code, 4'h9);

    // reset in the middle of debouncing key A
    repeat (2) run_scan(16'h1000);
    do_reset();
    p0 = pulse_cnt;
    repeat (2) run_scan(16'h1000);
    chk("rstmid_early", pulse_cnt - p0, 0);
    run_scan(16'h1000);
    chk("rstmid_code", key_code, 4'hA);
    repeat (3) run_scan('0);
    chk("rstmid_pulses", pulse_cnt, m_pulses);

    // random patterns held for a few scans each
    p = '0;
    for (int s = 0; s < 80; s++) begin
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 4))
          0:       p = '0;
          1:       p = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
          default: p = 16'h1 << $urandom_range(0, 15);
        endcase
      end
      run_scan(p);
    end
    repeat (3) run_scan('0);
    chk("random_pulses", pulse_cnt, m_pulses);

    // long hold of key 3 (col2,row0)
    p0 = pulse_cnt;
    repeat (16) run_scan(16'h0100);
    repeat (3) run_scan('0);
`ifdef KEYPAD_REPEAT_EN
    chk("hold_pulses", pulse_cnt - p0, 3);
`else
    chk("hold_pulses", pulse_cnt - p0, 1);
`endif
    chk("hold_code", key_code, 4'h3);
    chk("total_pulses", pulse_cnt, m_pulses);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
